// File: rtl/conv_accum_ctrl.sv
// rtl/conv_accum_ctrl.sv - multi-pass adder-tree sequencer with saturating accumulator
// Optional macro ACC_BIAS_EN adds i_bias, loaded into the accumulator at start.
module conv_accum_ctrl #(
    parameter int SUM_W  = 8,
    parameter int ACC_W  = 16,
    parameter int PASS_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [PASS_W-1:0] i_num_passes,
`ifdef ACC_BIAS_EN
    input  logic [ACC_W-1:0]  i_bias,
`endif
    output logic              o_busy,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_add_en,
    input  logic [SUM_W-1:0]  i_add_sum,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ACC_W-1:0]  o_out_data,
    output logic              o_sat
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [PASS_W-1:0] r_npass;
    logic [PASS_W-1:0] r_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic              r_sat;
    logic              r_busy;
    logic              r_in_ready;
    logic              r_out_valid;

    logic [ACC_W-1:0]  w_init_acc;
    logic [ACC_W:0]    w_sum;
    logic [PASS_W-1:0] w_cnt_next;
    logic              w_last;

`ifdef ACC_BIAS_EN
    assign w_init_acc = i_bias;
`else
    assign w_init_acc = '0;
`endif

    // One extra bit catches the carry that triggers the clamp.
    assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(i_add_sum);
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_last     = (w_cnt_next == r_npass);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_npass     <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_npass <= i_num_passes;
                        r_acc   <= w_init_acc;
                        r_cnt   <= '0;
                        r_sat   <= 1'b0;
                        r_busy  <= 1'b1;
                        if (i_num_passes == '0) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= S_ISSUE;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_in_valid) begin
                        r_state    <= S_CAPTURE;
                        r_in_ready <= 1'b0;
                    end
                end
                // The adder clears add_sum on the next edge, so this is the only sample point.
                S_CAPTURE: begin
                    if (w_sum[ACC_W]) begin
                        r_acc <= '1;
                        r_sat <= 1'b1;
                    end else begin
                        r_acc <= w_sum[ACC_W-1:0];
                    end
                    r_cnt <= w_cnt_next;
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state    <= S_ISSUE;
                        r_in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_in_ready  = r_in_ready;
    assign o_add_en    = i_in_valid & r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_acc;
    assign o_sat       = r_sat;

endmodule

// File: tb/tb_conv_accum_ctrl.sv
// tb/tb_conv_accum_ctrl.sv - scoreboard bench for conv_accum_ctrl with a registered adder model
// Define ACC_BIAS_EN to also exercise the bias port.
module tb_conv_accum_ctrl;

    localparam int SUM_W  = 8;
    localparam int ACC_W  = 9;
    localparam int PASS_W = 4;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic             sat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start;
    logic [PASS_W-1:0] num_passes;
    logic              in_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  add_sum;
`ifdef ACC_BIAS_EN
    logic [ACC_W-1:0]  bias;
`endif
    logic              busy;
    logic              in_ready;
    logic              add_en;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic              sat;

    exp_t             exp_q[$];
    logic [SUM_W-1:0] op_q[$];
    int checks   = 0;
    int errors   = 0;
    int hs_count = 0;
    int ae_count = 0;

    conv_accum_ctrl #(.SUM_W(SUM_W), .ACC_W(ACC_W), .PASS_W(PASS_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_num_passes (num_passes),
`ifdef ACC_BIAS_EN
        .i_bias       (bias),
`endif
        .o_busy       (busy),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .o_add_en     (add_en),
        .i_add_sum    (add_sum),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_sat        (sat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Registered adder: result of an enabled pass appears next cycle, then clears.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_sum <= '0;
        end else if (add_en) begin
            if (op_q.size() > 0) begin
                add_sum <= op_q.pop_front();
            end else begin
                add_sum <= '0;
                checks++;
                errors++;
                $display("FAIL adder_operand: got add_en with no operand queued required none");
            end
        end else begin
            add_sum <= '0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        check("add_en_is_valid_and_ready", {31'b0, add_en}, {31'b0, in_valid & in_ready});
        if (rst_n && add_en) ae_count++;
        if (rst_n && out_valid && out_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got out_data=%0d required no result", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", {23'b0, out_data}, {23'b0, e.data});
                check("sat", {31'b0, sat}, {31'b0, e.sat});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int n, input logic [ACC_W-1:0] d, input logic s);
        exp_q.push_back('{data: d, sat: s});
        start      = 1'b1;
        num_passes = n[PASS_W-1:0];
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy=1 required 0", name);
        end
        tick();
    endtask

    task automatic wait_out_valid(input string name);
        int k;
        k = 0;
        while (!out_valid && k < 40) begin
            tick();
            k++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got out_valid=0 required 1", name);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, {31'b0, busy}, 0);
        check({name, "_in_ready"}, {31'b0, in_ready}, 0);
        check({name, "_add_en"}, {31'b0, add_en}, 0);
        check({name, "_out_valid"}, {31'b0, out_valid}, 0);
        check({name, "_out_data"}, {23'b0, out_data}, 0);
        check({name, "_sat"}, {31'b0, sat}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] ae_trace;
        logic [8:0] ov_trace;
        logic       stall_ae;
        int         hs0;
        int         a0;
        logic [ACC_W-1:0] zero_exp;

        rst_n      = 1'b0;
        start      = 1'b0;
        num_passes = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
`ifdef ACC_BIAS_EN
        bias       = '0;
`endif
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic 3 passes: add_en in cycles 1,3,5 and out_valid in cycle 7.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        op_q.push_back(8'd10);
        op_q.push_back(8'd20);
        op_q.push_back(8'd30);
        exp_q.push_back('{data: 9'd60, sat: 1'b0});
        start      = 1'b1;
        num_passes = 4'd3;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            ae_trace[k] = add_en;
            ov_trace[k] = out_valid;
            tick();
            start = 1'b0;
        end
        check("basic_add_en_cycles", {23'b0, ae_trace}, 32'h02A);
        check("basic_out_valid_cycle", {23'b0, ov_trace}, 32'h080);

        // Upstream stall before pass 2, downstream back-pressure in DONE.
        out_ready = 1'b0;
        op_q.push_back(8'd7);
        op_q.push_back(8'd9);
        start_job(2, 9'd16, 1'b0);
        tick();
        in_valid = 1'b0;
        stall_ae = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            stall_ae = stall_ae | add_en;
            tick();
        end
        check("stall_add_en", {31'b0, stall_ae}, 0);
        check("stall_in_ready", {31'b0, in_ready}, 1);
        in_valid = 1'b1;
        wait_out_valid("stall");
        hs0 = hs_count;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("backpressure_out_valid", {31'b0, out_valid}, 1);
            check("backpressure_out_data", {23'b0, out_data}, 16);
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        check("stall_handshakes", hs_count - hs0, 1);
        check("stall_out_valid_dropped", {31'b0, out_valid}, 0);

        // Saturation, then a clean job clears sat.
        for (int k = 0; k < 3; k++) op_q.push_back(8'd255);
        start_job(3, 9'd511, 1'b1);
        wait_idle("saturate");
        op_q.push_back(8'd7);
        start_job(1, 9'd7, 1'b0);
        wait_idle("after_saturate");

        // Zero passes: result the cycle after IDLE, no adder activity.
`ifdef ACC_BIAS_EN
        bias     = 9'd33;
        zero_exp = 9'd33;
`else
        zero_exp = 9'd0;
`endif
        a0 = ae_count;
        start_job(0, zero_exp, 1'b0);
        check("zero_pass_out_valid", {31'b0, out_valid}, 1);
        wait_idle("zero_pass");
        check("zero_pass_add_en_count", ae_count - a0, 0);
`ifdef ACC_BIAS_EN
        bias = '0;
`endif

        // Start while busy in ISSUE must not reload npass.
        in_valid = 1'b0;
        op_q.push_back(8'd3);
        op_q.push_back(8'd4);
        a0 = ae_count;
        start_job(2, 9'd7, 1'b0);
        start      = 1'b1;
        num_passes = 4'd5;
        tick();
        start = 1'b0;
        check("busy_start_in_ready", {31'b0, in_ready}, 1);
        in_valid = 1'b1;
        wait_idle("busy_start");
        check("busy_start_add_en_count", ae_count - a0, 2);

        // Start coinciding with the DONE->IDLE handshake is ignored.
        out_ready = 1'b0;
        op_q.push_back(8'd4);
        start_job(1, 9'd4, 1'b0);
        wait_out_valid("handshake_start");
        hs0        = hs_count;
        start      = 1'b1;
        num_passes = 4'd1;
        out_ready  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("handshake_start_busy", {31'b0, busy}, 0);
        check("handshake_start_results", hs_count - hs0, 1);

        // Reset in CAPTURE of pass 2 of 4 abandons the job.
        op_q.push_back(8'd1);
        op_q.push_back(8'd2);
        op_q.push_back(8'd3);
        op_q.push_back(8'd4);
        start      = 1'b1;
        num_passes = 4'd4;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("midjob_busy_before_reset", {31'b0, busy}, 1);
        check("midjob_acc_before_reset", {23'b0, out_data}, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        op_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        op_q.push_back(8'd5);
        start_job(1, 9'd5, 1'b0);
        wait_idle("after_reset");

`ifdef ACC_BIAS_EN
        bias = 9'd100;
        op_q.push_back(8'd50);
        op_q.push_back(8'd200);
        start_job(2, 9'd350, 1'b0);
        wait_idle("bias");
        bias = '0;
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        check("operands_consumed", op_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
